// File: rtl/lpddr4_dfi_cmd_decoder_pkg.sv
// Shared types for the LPDDR4 DFI command decoder: command codes, part
// opcodes, pairing-FSM states, the queued command record and a part decoder.
package mc_lpddr4_pkg;

  typedef enum logic [3:0] {
    CMD_ACT, CMD_RD, CMD_WR, CMD_MWR, CMD_MRR, CMD_MRW,
    CMD_PRE, CMD_REF, CMD_SRE, CMD_SRX, CMD_MPC, CMD_UNK
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_IDLE, ST_WAIT_ACT2, ST_WAIT_CAS2, ST_WAIT_MRW2
  } fsm_state_e;

  // Role of one two-tick part in command assembly
  typedef enum logic [2:0] {
    PK_ACT1, PK_ACT2, PK_CAS1, PK_CAS2, PK_MRW1, PK_MRW2, PK_SINGLE
  } part_kind_e;

  typedef struct packed {
    cmd_type_e   ctype;
    logic [2:0]  bank;
    logic [23:0] operand;
  } cmd_t;

  typedef struct packed {
    part_kind_e kind;
    cmd_type_e  ctype;
  } part_t;

  // Part opcodes on t1 CA[4:0]; ACT parts are recognised by CA[1:0] alone
  localparam logic [4:0] OP_PRE  = 5'b10000;
  localparam logic [4:0] OP_REF  = 5'b01000;
  localparam logic [4:0] OP_SRE  = 5'b11000;
  localparam logic [4:0] OP_WR1  = 5'b00100;
  localparam logic [4:0] OP_SRX  = 5'b10100;
  localparam logic [4:0] OP_MWR1 = 5'b01100;
  localparam logic [4:0] OP_RD1  = 5'b00010;
  localparam logic [4:0] OP_CAS2 = 5'b10010;
  localparam logic [4:0] OP_MRW1 = 5'b00110;
  localparam logic [4:0] OP_MRW2 = 5'b10110;
  localparam logic [4:0] OP_MRR1 = 5'b01110;
  localparam logic [4:0] OP_MPC  = 5'b00000;

  // Classify a part from its t1 CA; unrecognised opcodes become single UNK
  function automatic part_t decode_part(input logic [5:0] ca);
    part_t p;
    p.kind  = PK_SINGLE;
    p.ctype = CMD_UNK;
    if (ca[0]) begin
      p.kind  = ca[1] ? PK_ACT2 : PK_ACT1;
      p.ctype = CMD_ACT;
    end else begin
      case (ca[4:0])
        OP_PRE:  p.ctype = CMD_PRE;
        OP_REF:  p.ctype = CMD_REF;
        OP_SRE:  p.ctype = CMD_SRE;
        OP_SRX:  p.ctype = CMD_SRX;
        OP_MPC:  p.ctype = ca[5] ? CMD_MPC : CMD_UNK;
        OP_WR1:  begin p.kind = PK_CAS1; p.ctype = CMD_WR;  end
        OP_MWR1: begin p.kind = PK_CAS1; p.ctype = CMD_MWR; end
        OP_RD1:  begin p.kind = PK_CAS1; p.ctype = CMD_RD;  end
        OP_MRR1: begin p.kind = PK_CAS1; p.ctype = CMD_MRR; end
        OP_CAS2: p.kind = PK_CAS2;
        OP_MRW1: begin p.kind = PK_MRW1; p.ctype = CMD_MRW; end
        OP_MRW2: p.kind = PK_MRW2;
        default: p.ctype = CMD_UNK;
      endcase
    end
    return p;
  endfunction

endpackage

// File: rtl/lpddr4_dfi_cmd_decoder_cmd_fifo.sv
// Two-write / one-read first-word-fall-through command queue. Each write
// port is checked against free space on its own; a rejected write raises a
// one-cycle overflow pulse. A pop in the same cycle frees a slot for writes.
module lpddr4_cmd_fifo
  import mc_lpddr4_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic wr0_en_i,
  input  cmd_t wr0_data_i,
  input  logic wr1_en_i,
  input  cmd_t wr1_data_i,
  output logic rd_valid_o,
  input  logic rd_ready_i,
  output cmd_t rd_data_o,
  output logic overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  cmd_t           mem_q [FIFO_DEPTH];
  logic [AW:0]    wptr_q, rptr_q, wptr_d, rptr_d;
  logic [AW:0]    count, free, wptr1;
  logic           pop, acc0, acc1;

  assign count      = wptr_q - rptr_q;
  assign rd_valid_o = (count != '0);
  assign pop        = rd_valid_o && rd_ready_i;
  assign free       = (AW+1)'(FIFO_DEPTH) - count + (AW+1)'(pop);
  assign acc0       = wr0_en_i && (free != '0);
  assign acc1       = wr1_en_i && (free > (AW+1)'(acc0));
  assign wptr1      = wptr_q + (AW+1)'(acc0);
  assign overflow_o = (wr0_en_i && !acc0) || (wr1_en_i && !acc1);
  assign rd_data_o  = rd_valid_o ? mem_q[rptr_q[AW-1:0]] : '0;
  assign wptr_d     = wptr_q + (AW+1)'(acc0) + (AW+1)'(acc1);
  assign rptr_d     = rptr_q + (AW+1)'(pop);

  // Storage writes; port 1 lands behind port 0 when both are accepted
  always_ff @(posedge clk_i) begin
    if (acc0) mem_q[wptr_q[AW-1:0]] <= wr0_data_i;
    if (acc1) mem_q[wptr1[AW-1:0]]  <= wr1_data_i;
  end

  // Pointer update; the extra MSB separates full from empty
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/lpddr4_dfi_cmd_decoder.sv
// LPDDR4 DFI CS/CA command decoder. Walks the four phase ticks of each cycle
// in order, forms two-tick parts, pairs first and second parts with a small
// FSM and queues complete commands. Optional checking is enabled with the
// macro LPDDR4_PROTO_CHECK_EN (sticky proto_err on pairing violations, UNK
// opcodes and CS asserted on a t2 tick); without it proto_err is tied low.
module lpddr4_dfi_cmd_decoder
  import mc_lpddr4_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  dfi_cs,
  input  logic [23:0] dfi_ca,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_type,
  output logic [2:0]  cmd_bank,
  output logic [23:0] cmd_operand,
  output logic        overflow,
  output logic        proto_err
);

  fsm_state_e  state_q, state_d;
  logic        carry_pend_q, carry_pend_d;
  logic [5:0]  carry_ca_q, carry_ca_d;
  logic [5:0]  pend_t1_q, pend_t1_d, pend_t2_q, pend_t2_d;
  cmd_type_e   cas_kind_q, cas_kind_d;
  logic        overflow_q;

  cmd_t        emit0, emit1, new_cmd, head;
  logic        emit0_vld, emit1_vld, new_vld;
  logic        have_t1, idle_pass, pair_ok, viol;
  logic [5:0]  t1_ca, t2_ca;
  part_t       part;
  cmd_type_e   pair_type;
  logic        fifo_ovf;

  // Tick walk: forms parts, advances the pairing FSM, collects up to two commands
  always_comb begin
    state_d      = state_q;
    pend_t1_d    = pend_t1_q;
    pend_t2_d    = pend_t2_q;
    cas_kind_d   = cas_kind_q;
    emit0        = '0;
    emit1        = '0;
    emit0_vld    = 1'b0;
    emit1_vld    = 1'b0;
    viol         = 1'b0;
    have_t1      = carry_pend_q;
    t1_ca        = carry_ca_q;
    t2_ca        = '0;
    part         = '0;
    new_cmd      = '0;
    new_vld      = 1'b0;
    idle_pass    = 1'b0;
    pair_ok      = 1'b0;
    pair_type    = CMD_UNK;
    for (int i = 0; i < 4; i++) begin
      new_vld = 1'b0;
      new_cmd = '0;
      if (have_t1) begin
        // This tick closes the open part even if CS is high on it
        t2_ca     = dfi_ca[6*i +: 6];
        viol      = viol | dfi_cs[i];
        part      = decode_part(t1_ca);
        idle_pass = (state_d == ST_IDLE);
        pair_ok   = 1'b0;
        pair_type = CMD_UNK;
        case (state_d)
          ST_WAIT_ACT2: begin pair_ok = (part.kind == PK_ACT2); pair_type = CMD_ACT;    end
          ST_WAIT_CAS2: begin pair_ok = (part.kind == PK_CAS2); pair_type = cas_kind_d; end
          ST_WAIT_MRW2: begin pair_ok = (part.kind == PK_MRW2); pair_type = CMD_MRW;    end
          default: ;
        endcase
        if (state_d != ST_IDLE) begin
          if (pair_ok) begin
            new_cmd.ctype   = pair_type;
            new_cmd.bank    = pend_t2_d[2:0];
            new_cmd.operand = {t2_ca, t1_ca, pend_t2_d, pend_t1_d};
            new_vld         = 1'b1;
          end else begin
            // Abandon the pending first part and treat this part afresh
            viol      = 1'b1;
            idle_pass = 1'b1;
          end
          state_d = ST_IDLE;
        end
        if (idle_pass) begin
          case (part.kind)
            PK_ACT1: begin
              state_d   = ST_WAIT_ACT2;
              pend_t1_d = t1_ca;
              pend_t2_d = t2_ca;
            end
            PK_CAS1: begin
              state_d    = ST_WAIT_CAS2;
              pend_t1_d  = t1_ca;
              pend_t2_d  = t2_ca;
              cas_kind_d = part.ctype;
            end
            PK_MRW1: begin
              state_d   = ST_WAIT_MRW2;
              pend_t1_d = t1_ca;
              pend_t2_d = t2_ca;
            end
            PK_SINGLE: begin
              new_cmd.ctype   = part.ctype;
              new_cmd.bank    = t2_ca[2:0];
              new_cmd.operand = {12'b0, t2_ca, t1_ca};
              new_vld         = 1'b1;
              viol            = viol | (part.ctype == CMD_UNK);
            end
            default: viol = 1'b1;  // second part with no first part: dropped
          endcase
        end
        if (new_vld) begin
          if (!emit0_vld) begin
            emit0     = new_cmd;
            emit0_vld = 1'b1;
          end else begin
            emit1     = new_cmd;
            emit1_vld = 1'b1;
          end
        end
        have_t1 = 1'b0;
      end else if (dfi_cs[i]) begin
        have_t1 = 1'b1;
        t1_ca   = dfi_ca[6*i +: 6];
      end
    end
    // Only a t1 on p3 can still be open here; it pairs with next cycle's p0
    carry_pend_d = have_t1;
    carry_ca_d   = t1_ca;
  end

  // Control state: FSM, carry flag and sticky overflow
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      carry_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      carry_pend_q <= carry_pend_d;
      overflow_q   <= overflow_q | fifo_ovf;
    end
  end

  // Captured tick data for the carry and the pending first part
  always_ff @(posedge sys_clk) begin
    carry_ca_q <= carry_ca_d;
    pend_t1_q  <= pend_t1_d;
    pend_t2_q  <= pend_t2_d;
    cas_kind_q <= cas_kind_d;
  end

  lpddr4_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (sys_clk),
    .rst_i      (sys_rst),
    .wr0_en_i   (emit0_vld && !sys_rst),
    .wr0_data_i (emit0),
    .wr1_en_i   (emit1_vld && !sys_rst),
    .wr1_data_i (emit1),
    .rd_valid_o (cmd_valid),
    .rd_ready_i (cmd_ready),
    .rd_data_o  (head),
    .overflow_o (fifo_ovf)
  );

  assign cmd_type    = head.ctype;
  assign cmd_bank    = head.bank;
  assign cmd_operand = head.operand;
  assign overflow    = overflow_q;

`ifdef LPDDR4_PROTO_CHECK_EN
  logic proto_err_q;

  // Sticky protocol-violation flag
  always_ff @(posedge sys_clk) begin
    if (sys_rst) proto_err_q <= 1'b0;
    else         proto_err_q <= proto_err_q | viol;
  end

  assign proto_err = proto_err_q;
`else
  logic unused_viol;
  assign unused_viol = viol;
  assign proto_err   = 1'b0;
`endif

endmodule

// File: tb/tb_lpddr4_dfi_cmd_decoder.sv
// Bench for lpddr4_dfi_cmd_decoder: a table of directed cycles with
// hand-derived expectations, then randomized CS/CA traffic checked against
// a tick-stream reference model. Honours LPDDR4_PROTO_CHECK_EN.
module tb_lpddr4_dfi_cmd_decoder;

  localparam int DEPTH = 8;
`ifdef LPDDR4_PROTO_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  dfi_cs;
  logic [23:0] dfi_ca;
  logic        cmd_valid, cmd_ready, overflow, proto_err;
  logic [3:0]  cmd_type;
  logic [2:0]  cmd_bank;
  logic [23:0] cmd_operand;

  always #5 sys_clk = ~sys_clk;

  lpddr4_dfi_cmd_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dfi_cs(dfi_cs), .dfi_ca(dfi_ca),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_bank(cmd_bank), .cmd_operand(cmd_operand), .overflow(overflow),
    .proto_err(proto_err)
  );

  typedef struct {
    string      name;
    bit         rst;
    bit [3:0]   cs;
    bit [23:0]  ca;
    bit         rdy;
    bit         v;
    int         t;
    bit [2:0]   b;
    bit [23:0]  op;
    bit         ovf;
    bit         perr;
  } vec_t;

  typedef struct {
    int        t;
    bit [2:0]  b;
    bit [23:0] op;
  } mcmd_t;

  vec_t  tbl[$];
  mcmd_t mq[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model state: open t1 in the tick stream, pending first part, flags
  bit        m_t1;
  bit [5:0]  m_t1v;
  bit        m_first;
  string     m_fname;
  bit [5:0]  m_f1, m_f2;
  bit        m_ovf, m_perr;

  function automatic bit [23:0] ca4(bit [5:0] a0, bit [5:0] a1, bit [5:0] a2, bit [5:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic string part_name(bit [5:0] c);
    if (c[0]) return c[1] ? "ACT2" : "ACT1";
    case (c[4:0])
      5'b10000: return "PRE";
      5'b01000: return "REF";
      5'b11000: return "SRE";
      5'b00100: return "WR1";
      5'b10100: return "SRX";
      5'b01100: return "MWR1";
      5'b00010: return "RD1";
      5'b10010: return "CAS2";
      5'b00110: return "MRW1";
      5'b10110: return "MRW2";
      5'b01110: return "MRR1";
      5'b00000: return c[5] ? "MPC" : "UNK";
      default:  return "UNK";
    endcase
  endfunction

  function automatic string partner(string f);
    if (f == "ACT1") return "ACT2";
    if (f == "RD1" || f == "WR1" || f == "MWR1" || f == "MRR1") return "CAS2";
    if (f == "MRW1") return "MRW2";
    return "";
  endfunction

  // Command codes follow the order ACT, RD, WR, MWR, MRR, MRW, PRE, REF, SRE, SRX, MPC, UNK
  function automatic int type_code(string s);
    if (s == "ACT1") return 0;
    if (s == "RD1")  return 1;
    if (s == "WR1")  return 2;
    if (s == "MWR1") return 3;
    if (s == "MRR1") return 4;
    if (s == "MRW1") return 5;
    if (s == "PRE")  return 6;
    if (s == "REF")  return 7;
    if (s == "SRE")  return 8;
    if (s == "SRX")  return 9;
    if (s == "MPC")  return 10;
    return 11;
  endfunction

  task automatic m_emit(int t, bit [2:0] b, bit [23:0] op);
    mcmd_t c;
    c.t = t; c.b = b; c.op = op;
    if (mq.size() < DEPTH) mq.push_back(c);
    else m_ovf = 1'b1;
  endtask

  task automatic m_part(bit [5:0] t1, bit [5:0] t2);
    string n;
    n = part_name(t1);
    if (m_first) begin
      m_first = 1'b0;
      if (n == partner(m_fname)) begin
        m_emit(type_code(m_fname), m_f2[2:0], {t2, t1, m_f2, m_f1});
        return;
      end
      m_perr = 1'b1;
    end
    if (partner(n) != "") begin
      m_first = 1'b1; m_fname = n; m_f1 = t1; m_f2 = t2;
    end else if (n == "ACT2" || n == "CAS2" || n == "MRW2") begin
      m_perr = 1'b1;
    end else begin
      m_emit(type_code(n), t2[2:0], {12'b0, t2, t1});
      if (n == "UNK") m_perr = 1'b1;
    end
  endtask

  task automatic m_step(bit rst, bit [3:0] cs, bit [23:0] ca, bit rdy);
    bit [5:0] c;
    if (rst) begin
      mq.delete();
      m_t1 = 1'b0; m_first = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
      return;
    end
    if (rdy && mq.size() > 0) void'(mq.pop_front());
    for (int i = 0; i < 4; i++) begin
      c = ca[6*i +: 6];
      if (m_t1) begin
        m_part(m_t1v, c);
        if (cs[i]) m_perr = 1'b1;
        m_t1 = 1'b0;
      end else if (cs[i]) begin
        m_t1 = 1'b1; m_t1v = c;
      end
    end
  endtask

  task automatic apply(bit rst, bit [3:0] cs, bit [23:0] ca, bit rdy);
    @(negedge sys_clk);
    sys_rst = rst; dfi_cs = cs; dfi_ca = ca; cmd_ready = rdy;
    m_step(rst, cs, ca, rdy);
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(string n, bit v, int t, bit [2:0] b, bit [23:0] op, bit ovf, bit perr);
    vectors++;
    if (cmd_valid !== v || cmd_type !== 4'(t) || cmd_bank !== b || cmd_operand !== op ||
        overflow !== ovf || proto_err !== perr) begin
      miscompares++;
      $display("FAIL %s @%0t: got v=%0b type=%0d bank=%0d op=%h ovf=%0b perr=%0b, want v=%0b type=%0d bank=%0d op=%h ovf=%0b perr=%0b",
               n, $time, cmd_valid, cmd_type, cmd_bank, cmd_operand, overflow, proto_err,
               v, t, b, op, ovf, perr);
    end
  endtask

  task automatic add(string n, bit rst, bit [3:0] cs, bit [23:0] ca, bit rdy,
                     bit v, int t, bit [2:0] b, bit [23:0] op, bit ovf, bit perr);
    vec_t r;
    r.name = n; r.rst = rst; r.cs = cs; r.ca = ca; r.rdy = rdy;
    r.v = v; r.t = t; r.b = b; r.op = op; r.ovf = ovf; r.perr = perr;
    tbl.push_back(r);
  endtask

  bit [4:0] oplist [14] = '{5'b00001, 5'b00011, 5'b10000, 5'b01000, 5'b11000, 5'b00100, 5'b10100,
                            5'b01100, 5'b00010, 5'b10010, 5'b00110, 5'b10110, 5'b01110, 5'b00000};

  function automatic bit [5:0] rnd_ca();
    bit [4:0] o;
    if ($urandom_range(0, 9) < 2) return 6'($urandom);
    o = oplist[$urandom_range(0, 13)];
    if (o[0]) o[4:2] = 3'($urandom);
    return {1'($urandom), o};
  endfunction

  initial begin
    bit [3:0]  rcs;
    bit [23:0] rca;
    bit        rrst, rrdy;
    sys_rst = 1'b1; dfi_cs = '0; dfi_ca = '0; cmd_ready = 1'b0;

    add("reset", 1, 4'b0000, 24'h0, 0, 0, 0, 0, 24'h0, 0, 0);
    add("ref_one_cycle", 0, 4'b0010, ca4(6'h00, 6'h08, 6'h00, 6'h00), 0, 1, 7, 0, 24'h000008, 0, 0);
    add("ref_pop", 0, 4'b0000, 24'h0, 1, 0, 0, 0, 24'h0, 0, 0);
    add("act1_on_p3", 0, 4'b1000, ca4(6'h00, 6'h00, 6'h00, 6'h21), 0, 0, 0, 0, 24'h0, 0, 0);
    add("act_split", 0, 4'b0010, ca4(6'h05, 6'h13, 6'h38, 6'h00), 0, 1, 0, 5, 24'hE13161, 0, 0);
    add("act_pop", 0, 4'b0000, 24'h0, 1, 0, 0, 0, 24'h0, 0, 0);
    add("rd_same_cycle", 0, 4'b0101, ca4(6'h02, 6'h03, 6'h12, 6'h2A), 0, 1, 1, 3, 24'hA920C2, 0, 0);
    add("rd_pop_single", 0, 4'b0000, 24'h0, 1, 0, 0, 0, 24'h0, 0, 0);
    add("reset_b", 1, 4'b0000, 24'h0, 0, 0, 0, 0, 24'h0, 0, 0);
    for (int c = 0; c < 5; c++)
      add("fill_pre_ref", 0, 4'b0101, ca4(6'h10, 6'(2*c), 6'h08, 6'(2*c+1)), 0,
          1, 6, 0, 24'h000010, (c == 4), 0);
    for (int j = 1; j <= 8; j++)
      if (j < 8)
        add("drain_order", 0, 4'b0000, 24'h0, 1, 1, (j % 2 == 0) ? 6 : 7, 3'(j),
            {12'b0, 6'(j), (j % 2 == 0) ? 6'h10 : 6'h08}, 1, 0);
      else
        add("drain_empty", 0, 4'b0000, 24'h0, 1, 0, 0, 0, 24'h0, 1, 0);
    add("reset_c", 1, 4'b0000, 24'h0, 0, 0, 0, 0, 24'h0, 0, 0);
    add("wr1_then_pre", 0, 4'b0101, ca4(6'h04, 6'h01, 6'h10, 6'h06), 0, 1, 6, 6, 24'h000190, 0, PCHK);
    add("pre_pop", 0, 4'b0000, 24'h0, 1, 0, 0, 0, 24'h0, 0, PCHK);
    add("reset_d", 1, 4'b0000, 24'h0, 0, 0, 0, 0, 24'h0, 0, 0);
    add("queue_pre_ref", 0, 4'b0101, ca4(6'h10, 6'h01, 6'h08, 6'h02), 0, 1, 6, 1, 24'h000050, 0, 0);
    add("queue_sre_rd1", 0, 4'b0101, ca4(6'h18, 6'h03, 6'h02, 6'h04), 0, 1, 6, 1, 24'h000050, 0, 0);
    add("reset_in_wait", 1, 4'b0000, 24'h0, 0, 0, 0, 0, 24'h0, 0, 0);
    add("orphan_cas2", 0, 4'b0001, ca4(6'h12, 6'h00, 6'h00, 6'h00), 0, 0, 0, 0, 24'h0, 0, PCHK);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].cs, tbl[i].ca, tbl[i].rdy);
      check(tbl[i].name, tbl[i].v, tbl[i].t, tbl[i].b, tbl[i].op, tbl[i].ovf, tbl[i].perr);
    end

    apply(1'b1, 4'b0000, 24'h0, 1'b0);
    check("rand_reset", 1'b0, 0, 3'd0, 24'h0, 1'b0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      rrst = ($urandom_range(0, 149) == 0);
      rrdy = ($urandom_range(0, 99) < 45);
      for (int p = 0; p < 4; p++) begin
        rcs[p] = ($urandom_range(0, 99) < 35);
        rca[6*p +: 6] = rnd_ca();
      end
      apply(rrst, rcs, rca, rrdy);
      if (mq.size() > 0)
        check("random", 1'b1, mq[0].t, mq[0].b, mq[0].op, m_ovf, PCHK & m_perr);
      else
        check("random", 1'b0, 0, 3'd0, 24'h0, m_ovf, PCHK & m_perr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpddr4_dfi_cmd_decoder.md
Name: lpddr4_dfi_cmd_decoder

Overview:
- PHY-side decoder for the 4-phase LPDDR4 DFI CS/CA stream that the controller emits. Recovers complete commands from the stream: ACT, RD, WR, MWR, MRR, MRW, PRE, REF, SRE, SRX, MPC.
- Output is a valid/ready command queue. Used by the PHY model, the protocol monitor and the bench scoreboard.

Parameters:
- FIFO_DEPTH, 8, command queue entries; power of 2, minimum 4.

Ports:
- sys_clk  input  1  system clock; all phases are sampled on the rising edge.
- sys_rst  input  1  synchronous, active-high reset.
- dfi_cs  input  4  CS per phase; bit n is phase n. Tick order within a cycle is p0, p1, p2, p3.
- dfi_ca  input  24  CA per phase; bits [6n+5:6n] are phase n, with CA0 at the LSB.
- cmd_valid  output  1  head of queue is valid.
- cmd_ready  input  1  consumer accepts the head when cmd_valid && cmd_ready.
- cmd_type  output  4  decoded command code (package enum).
- cmd_bank  output  3  bank, taken from tick-2 CA[2:0] of the first part.
- cmd_operand  output  24  raw operand {p2t2, p2t1, p1t2, p1t1}, 6 bits each; upper 12 bits are 0 for single-part commands.
- overflow  output  1  sticky; a command was dropped because the queue was full.
- proto_err  output  1  sticky protocol violation (PROTO_CHECK_EN only, else tied 0).

Behaviour:
- Reset values: cmd_valid=0, overflow=0, proto_err=0. Queue is emptied, tick carry cleared, FSM returns to IDLE.
  - cmd_type, cmd_bank and cmd_operand are 0 while the queue is empty.
  - Reset asserted mid-command discards any partial part or command.
- Parts: each part is a tick with CS=1 (t1) followed by the next tick (t2).
  - A t1 on p3 carries to p0 of the next cycle. The carry register holds the t1 CA and a pending flag.
  - The tick used as t2 is never treated as a new t1.
- Part opcode comes from t1 CA[4:0]:
  - ACT-1: CA[1:0]=01. ACT-2: CA[1:0]=11.
  - PRE 10000, REF 01000, SRE 11000, WR-1 00100, SRX 10100, MWR-1 01100, RD-1 00010, CAS-2 10010, MRW-1 00110, MRW-2 10110, MRR-1 01110.
  - MPC: 00000 with CA5=1. Any other opcode decodes as UNK.
- Pairing FSM, states IDLE, WAIT_ACT2, WAIT_CAS2, WAIT_MRW2:
  - IDLE + ACT-1 → WAIT_ACT2.
  - IDLE + RD-1, WR-1, MWR-1 or MRR-1 → WAIT_CAS2; the kind is latched.
  - IDLE + MRW-1 → WAIT_MRW2.
  - IDLE + a single-part command → emit it, stay in IDLE.
  - WAIT_x + its matching second part → emit the assembled command, go to IDLE.
  - WAIT_x + any other part → drop the pending first part, set proto_err, and reprocess the new part from IDLE.
  - A second part arriving in IDLE → dropped, proto_err set.
  - The FSM state may span clock cycles.
- Pushes per cycle:
  - At most 2 commands complete per cycle, because parts last 2 ticks.
  - The queue has 2 write ports. Commands are pushed in tick order.
  - Free space is checked per push. A push into a full queue is dropped and sets overflow; the earlier push in the same cycle still succeeds.
- Latency: a command whose last tick is in cycle N has cmd_valid=1 at N+1 if the queue was empty. The queue is first-word-fall-through.
- Push and pop in the same cycle while full: the pop frees one slot for that cycle's pushes.
- Output stability: fields are held stable while cmd_valid && !cmd_ready.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits; the MSB distinguishes full from empty.

Optional Feature:
- Macro: LPDDR4_PROTO_CHECK_EN.
- Defined:
  - proto_err goes sticky on an FSM violation, on UNK, or on CS=1 during a t2 tick.
  - In the CS=1-on-t2 case, the tick is still consumed as t2.
- Undefined:
  - proto_err is tied 0; violation logic is removed.
  - The FSM still drops mismatched parts silently.
  - UNK is still emitted as a command.

Decomposition:
- Package mc_lpddr4_pkg:
  - cmd_type enum: ACT, RD, WR, MWR, MRR, MRW, PRE, REF, SRE, SRX, MPC, UNK.
  - Part-opcode localparams.
  - FSM state enum.
  - Packed cmd struct {type, bank, operand}.
- Sub-module lpddr4_cmd_fifo: 2-write/1-read FWFT queue with per-port drop and an overflow pulse.

Test Plan:
- REF in one cycle: p1 cs=1 with ca=6'b001000, p2 cs=0 → next cycle cmd_valid=1, cmd_type=REF, operand[23:12]=0.
- ACT split across a cycle boundary: ACT-1 t1 on p3, t2 on next p0 with ca=6'b000101, then ACT-2 on p1/p2 → one ACT with cmd_bank=5 and 24-bit operand matching the ticks.
- RD-1 on p0/p1 and CAS-2 on p2/p3 in the same cycle → exactly one RD, queue count 1.
- PRE on p0/p1 and REF on p2/p3 for 5 consecutive cycles, cmd_ready=0, FIFO_DEPTH=8 → 8 entries in tick order, overflow=1 in the cycle the 9th push is dropped.
- WR-1 followed by a PRE part instead of CAS-2, macro defined → WR dropped, PRE emitted, proto_err=1.
- Assert sys_rst for one cycle while in WAIT_CAS2 with 3 queued entries → cmd_valid=0, flags 0; a following CAS-2 is flagged as an orphan.
